// File: rtl/cdma_pkg.sv
// Shared CDMA definitions: PN generator constants, sample/counter types and the code parity helper.
package cdma_pkg;

  localparam int LFSR_W = 6;
  localparam logic [LFSR_W-1:0] LFSR_SEED = 6'b000001;
  // Fibonacci taps for x^6 + x^5 + 1 (maximal length, period 63)
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 6'b110000;

  localparam int BPSK_AMP = 100;
  localparam int CNT_W    = 6;

  typedef logic signed [7:0] sample_t;
  typedef logic [CNT_W-1:0]  chip_cnt_t;

  typedef enum logic [0:0] {
    ST_ACCUM = 1'b0,
    ST_LAST  = 1'b1
  } state_t;

  function automatic logic code_parity(input logic [LFSR_W-1:0] pn, input logic [LFSR_W-1:0] code);
    return ^(pn & code);
  endfunction

endpackage

// File: rtl/cdma_despreader_lfsr.sv
// 6-bit PN generator shared with the spreader; free-running, reseeded by rst.
module cdma_despreader_lfsr
  import cdma_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  output logic [LFSR_W-1:0] pn_seq
);

  logic [LFSR_W-1:0] state_r;

  // Shift register advancing every clock so phase tracks the transmitter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= LFSR_SEED;
    end else begin
      state_r <= {state_r[LFSR_W-2:0], ^(state_r & LFSR_TAPS)};
    end
  end

  assign pn_seq = state_r;

endmodule

// File: rtl/cdma_despreader.sv
// BPSK CDMA despreader: PN-multiply, integrate over SF chips, hard decision and lock.
// Optional parallel correlator on the non-selected code via CDMA_DESPREADER_DUAL_EN.
module cdma_despreader
  import cdma_pkg::*;
#(
  parameter int SF     = 16,
  parameter int ACC_W  = 8 + $clog2(SF) + 1,
  parameter int THRESH = SF * BPSK_AMP / 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [7:0]       sample_in,
  input  logic                    sample_valid,
  input  logic [LFSR_W-1:0]       user_code_1,
  input  logic [LFSR_W-1:0]       user_code_2,
  input  logic                    user_select,
  input  logic                    flush,
  output logic                    data_out,
  output logic                    data_valid,
  output logic signed [ACC_W-1:0] corr_out,
`ifdef CDMA_DESPREADER_DUAL_EN
  output logic                    data_out_alt,
  output logic signed [ACC_W-1:0] corr_out_alt,
  output logic                    lock_alt,
`endif
  output logic                    lock
);

`ifdef CDMA_DESPREADER_DUAL_EN
  localparam int NCORR = 2;
`else
  localparam int NCORR = 1;
`endif

  logic [LFSR_W-1:0] pn_s;
  logic [LFSR_W-1:0] code_s [NCORR];
  state_t            state_r;
  state_t            state_nx_s;
  chip_cnt_t         chip_cnt_r;
  logic              dump_s;
  logic              data_valid_r;

  cdma_despreader_lfsr u_lfsr (
    .clk    (clk),
    .rst    (rst),
    .pn_seq (pn_s)
  );

  // Code routing: correlator 0 follows user_select, correlator 1 takes the other code
  always_comb begin
    for (int i = 0; i < NCORR; i++) begin
      if ((i == 0) ^ user_select) begin
        code_s[i] = user_code_1;
      end else begin
        code_s[i] = user_code_2;
      end
    end
  end

  // Symbol framing state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_ACCUM;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // ST_LAST marks the final chip of a symbol; flush always returns to the first chip
  always_comb begin
    state_nx_s = state_r;
    dump_s     = 1'b0;
    if (flush) begin
      state_nx_s = ST_ACCUM;
    end else begin
      case (state_r)
        ST_ACCUM: begin
          if (chip_cnt_r == CNT_W'(SF - 2)) begin
            state_nx_s = ST_LAST;
          end else begin
            state_nx_s = ST_ACCUM;
          end
        end
        ST_LAST: begin
          state_nx_s = ST_ACCUM;
          dump_s     = 1'b1;
        end
        default: begin
          state_nx_s = ST_ACCUM;
        end
      endcase
    end
  end

  // Chip counter and decision strobe
  always_ff @(posedge clk) begin
    if (rst) begin
      chip_cnt_r   <= {CNT_W{1'b0}};
      data_valid_r <= 1'b0;
    end else if (flush || dump_s) begin
      chip_cnt_r   <= {CNT_W{1'b0}};
      data_valid_r <= dump_s;
    end else begin
      chip_cnt_r   <= chip_cnt_r + 6'd1;
      data_valid_r <= 1'b0;
    end
  end

  for (genvar g = 0; g < NCORR; g++) begin : g_corr
    logic                    p_s;
    logic signed [ACC_W-1:0] ext_s;
    logic signed [ACC_W-1:0] chip_s;
    logic signed [ACC_W-1:0] sum_s;
    logic signed [ACC_W-1:0] mag_s;
    logic signed [ACC_W-1:0] acc_r;
    logic signed [ACC_W-1:0] corr_r;
    logic                    dec_r;
    logic                    lock_r;

    // Widen before negating so -128 maps to +128 rather than wrapping
    always_comb begin
      p_s   = code_parity(pn_s, code_s[g]);
      ext_s = ACC_W'(sample_in);
      if (!sample_valid) begin
        chip_s = {ACC_W{1'b0}};
      end else if (p_s) begin
        chip_s = -ext_s;
      end else begin
        chip_s = ext_s;
      end
      sum_s = acc_r + chip_s;
      if (sum_s[ACC_W-1]) begin
        mag_s = -sum_s;
      end else begin
        mag_s = sum_s;
      end
    end

    // Integrate-and-dump; decisions only change on a non-flushed last chip
    always_ff @(posedge clk) begin
      if (rst) begin
        acc_r  <= {ACC_W{1'b0}};
        corr_r <= {ACC_W{1'b0}};
        dec_r  <= 1'b0;
        lock_r <= 1'b0;
      end else if (flush) begin
        acc_r  <= {ACC_W{1'b0}};
      end else if (dump_s) begin
        acc_r  <= {ACC_W{1'b0}};
        corr_r <= sum_s;
        dec_r  <= !sum_s[ACC_W-1] && (sum_s != {ACC_W{1'b0}});
        lock_r <= (mag_s >= ACC_W'(THRESH));
      end else begin
        acc_r  <= sum_s;
      end
    end
  end

  assign data_valid = data_valid_r;
  assign data_out   = g_corr[0].dec_r;
  assign corr_out   = g_corr[0].corr_r;
  assign lock       = g_corr[0].lock_r;
`ifdef CDMA_DESPREADER_DUAL_EN
  assign data_out_alt = g_corr[1].dec_r;
  assign corr_out_alt = g_corr[1].corr_r;
  assign lock_alt     = g_corr[1].lock_r;
`endif

endmodule

// File: tb/tb_cdma_despreader.sv
// Self-checking bench for cdma_despreader: directed symbol table, flush/reset sequence, random run.
module tb_cdma_despreader;

  localparam int SF     = 16;
  localparam int ACC_W  = 8 + $clog2(SF) + 1;
  localparam int THRESH = SF * 100 / 4;

  logic                    clk;
  logic                    rst;
  logic signed [7:0]       sample_in;
  logic                    sample_valid;
  logic [5:0]              user_code_1;
  logic [5:0]              user_code_2;
  logic                    user_select;
  logic                    flush;
  logic                    data_out;
  logic                    data_valid;
  logic signed [ACC_W-1:0] corr_out;
  logic                    lock;
`ifdef CDMA_DESPREADER_DUAL_EN
  logic                    data_out_alt;
  logic signed [ACC_W-1:0] corr_out_alt;
  logic                    lock_alt;
`endif

  cdma_despreader #(.SF(SF), .ACC_W(ACC_W), .THRESH(THRESH)) dut (
    .clk          (clk),
    .rst          (rst),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .user_code_1  (user_code_1),
    .user_code_2  (user_code_2),
    .user_select  (user_select),
    .flush        (flush),
    .data_out     (data_out),
    .data_valid   (data_valid),
    .corr_out     (corr_out),
`ifdef CDMA_DESPREADER_DUAL_EN
    .data_out_alt (data_out_alt),
    .corr_out_alt (corr_out_alt),
    .lock_alt     (lock_alt),
`endif
    .lock         (lock)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [5:0] pn_tab [63];
  int         pn_idx;
  int         sym_q[$];
  int         alt_q[$];
  logic       e_dv, e_data, e_lock, e_data_alt, e_lock_alt;
  int         e_corr, e_corr_alt;

  typedef struct {
    logic        data;
    logic        sel;
    logic [15:0] erase;
    logic        zero;
    logic        kconst;
    int          ecorr;
    logic        edata;
    logic        elock;
  } vec_t;
  vec_t vecs [9];

  task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int abs_i(input int x);
    return (x < 0) ? -x : x;
  endfunction

  function automatic int sum_q(input int q[$]);
    int s = 0;
    foreach (q[i]) s += q[i];
    return s;
  endfunction

  // Transmitter chip for data bit d spread with code at the current PN phase
  function automatic int tx_chip(input logic d, input logic [5:0] code);
    logic p;
    p = ^(pn_tab[pn_idx] & code);
    return (d ^ p) ? 100 : -100;
  endfunction

  function automatic int despread(input int s, input logic v, input logic [5:0] code);
    logic p;
    p = ^(pn_tab[pn_idx] & code);
    if (!v) return 0;
    return p ? -s : s;
  endfunction

  task automatic check_outputs(input string tag);
    check({tag, ".data_valid"}, data_valid, e_dv);
    check({tag, ".data_out"},   data_out,   e_data);
    check({tag, ".corr_out"},   corr_out,   e_corr);
    check({tag, ".lock"},       lock,       e_lock);
`ifdef CDMA_DESPREADER_DUAL_EN
    check({tag, ".data_out_alt"}, data_out_alt, e_data_alt);
    check({tag, ".corr_out_alt"}, corr_out_alt, e_corr_alt);
    check({tag, ".lock_alt"},     lock_alt,     e_lock_alt);
`endif
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1; flush = 1'b0; sample_in = 8'sd0; sample_valid = 1'b0;
    @(posedge clk); #1;
    pn_idx = 0;
    sym_q.delete(); alt_q.delete();
    e_dv = 1'b0; e_data = 1'b0; e_corr = 0; e_lock = 1'b0;
    e_data_alt = 1'b0; e_corr_alt = 0; e_lock_alt = 1'b0;
    check_outputs(tag);
    rst = 1'b0;
  endtask

  // Apply one chip, advance the model by one symbol-chip and compare every output
  task automatic do_chip(input int s, input logic v, input logic f, input string tag);
    logic [5:0] code, code_alt;
    int         c, ca, sm;
    logic [31:0] sv;
    sv = s;
    sample_in = sv[7:0]; sample_valid = v; flush = f;
    code     = user_select ? user_code_2 : user_code_1;
    code_alt = user_select ? user_code_1 : user_code_2;
    c  = despread(s, v, code);
    ca = despread(s, v, code_alt);
    @(posedge clk); #1;
    pn_idx = (pn_idx + 1) % 63;
    e_dv = 1'b0;
    if (f) begin
      sym_q.delete(); alt_q.delete();
    end else begin
      sym_q.push_back(c); alt_q.push_back(ca);
      if (sym_q.size() == SF) begin
        sm = sum_q(sym_q);
        e_corr = sm; e_data = (sm > 0); e_lock = (abs_i(sm) >= THRESH);
        sm = sum_q(alt_q);
        e_corr_alt = sm; e_data_alt = (sm > 0); e_lock_alt = (abs_i(sm) >= THRESH);
        e_dv = 1'b1;
        sym_q.delete(); alt_q.delete();
      end
    end
    check_outputs(tag);
    flush = 1'b0;
  endtask

  initial begin
    int s, v, f, held;
    logic d;

    s = 6'b000001;
    for (int i = 0; i < 63; i++) begin
      pn_tab[i] = s[5:0];
      s = {s[4:0], s[5] ^ s[4]};
    end

    //         data  sel   erase     zero  kconst ecorr  edata elock
    vecs[0] = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b1,  1600, 1'b1, 1'b1};
    vecs[1] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, -1600, 1'b0, 1'b1};
    vecs[2] = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b1,  1600, 1'b1, 1'b1};
    vecs[3] = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b1,  1600, 1'b1, 1'b1};
    vecs[4] = '{1'b1, 1'b1, 16'h0000, 1'b0, 1'b0,     0, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 1'b1, 16'h0000, 1'b0, 1'b0,     0, 1'b0, 1'b0};
    vecs[6] = '{1'b1, 1'b1, 16'h0000, 1'b0, 1'b0,     0, 1'b0, 1'b0};
    vecs[7] = '{1'b1, 1'b0, 16'hAAAA, 1'b0, 1'b1,   800, 1'b1, 1'b1};
    vecs[8] = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b1,     0, 1'b0, 1'b0};

    user_code_1 = 6'b101101; user_code_2 = 6'b010011; user_select = 1'b0;
    do_reset("reset");
    do_reset("reset2");

    // Directed symbols: loopback, wrong code, erasure, tie
    for (int k = 0; k < 9; k++) begin
      user_select = vecs[k].sel;
      for (int ch = 0; ch < SF; ch++) begin
        s = vecs[k].zero ? 0 : tx_chip(vecs[k].data, user_code_1);
        do_chip(s, !vecs[k].erase[ch], 1'b0, $sformatf("vec%0d", k));
      end
      check($sformatf("vec%0d.pulse", k), data_valid, 1'b1);
      if (vecs[k].kconst) begin
        check($sformatf("vec%0d.corr_const", k), corr_out, vecs[k].ecorr);
        check($sformatf("vec%0d.data_const", k), data_out, vecs[k].edata);
        check($sformatf("vec%0d.lock_const", k), lock, vecs[k].elock);
      end
    end

    // Flush on the last chip, then reset part way through the next symbol
    user_select = 1'b0;
    held = e_corr;
    for (int ch = 0; ch < SF; ch++)
      do_chip(tx_chip(1'b1, user_code_1), 1'b1, (ch == SF - 1), "flush_sym");
    check("flush.no_valid", data_valid, 1'b0);
    check("flush.corr_held", corr_out, held);
    for (int ch = 0; ch < 7; ch++)
      do_chip(tx_chip(1'b0, user_code_1), 1'b1, 1'b0, "pre_rst");
    do_reset("mid_rst");
    check("mid_rst.corr_zero", corr_out, 0);
    for (int ch = 0; ch < SF; ch++) begin
      do_chip(tx_chip(1'b1, user_code_1), 1'b1, 1'b0, "post_rst");
      if (ch == SF - 2) check("post_rst.early", data_valid, 1'b0);
    end
    check("post_rst.valid", data_valid, 1'b1);
    check("post_rst.corr", corr_out, 1600);

    // Randomized run against the model; codes only change on symbol boundaries
    d = 1'b0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      if (sym_q.size() == 0) begin
        user_code_1 = 6'($urandom_range(0, 63));
        user_code_2 = 6'($urandom_range(0, 63));
        user_select = 1'($urandom_range(0, 1));
        d           = 1'($urandom_range(0, 1));
      end
      if ($urandom_range(0, 3) == 0)
        s = int'($urandom_range(0, 255)) - 128;
      else
        s = tx_chip(d, user_select ? user_code_2 : user_code_1) + int'($urandom_range(0, 54)) - 27;
      v = ($urandom_range(0, 9) != 0);
      f = ($urandom_range(0, 49) == 0);
      do_chip(s, v[0], f[0], "rand");
    end

`ifdef CDMA_DESPREADER_DUAL_EN
    // Two users superimposed and clipped at the receiver input
    do_reset("dual_rst");
    user_code_1 = 6'b101101; user_code_2 = 6'b010011; user_select = 1'b0;
    for (int sym = 0; sym < 3; sym++) begin
      for (int ch = 0; ch < SF; ch++) begin
        s = tx_chip(1'b1, user_code_1) + tx_chip(1'b0, user_code_2);
        if (s > 127) s = 127;
        if (s < -128) s = -128;
        do_chip(s, 1'b1, 1'b0, "dual");
      end
      check("dual.data_out_alt", data_out_alt, 1'b0);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
